sys_input_feeder: RTL and testbench

- Buffers a batch of 2-element input vectors from the unified-buffer read path.
- Streams the batch into the 2x2 systolic array's left edge (sys_data_in_1x / sys_data_in_2x / sys_start) with the one-cycle diagonal skew the array requires.
- Also issues the column-size configuration pulse that sets the array's PE enables.
- Sits directly upstream of the systolic array.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/sys_feeder_buf.sv | 27 ++
 rtl/sys_input_feeder.sv | 163 ++++++++++++++++
 tb/tb_sys_input_feeder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath.
// Used by the systolic-array input feeder.
package tpu_pkg;

  localparam int DATA_W = 16;
  localparam int COL_W  = 16;

  typedef enum logic [1:0] {
    LOAD,
    READY,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/sys_feeder_buf.sv
// Batch storage for the feeder.
// Register file: synchronous write, combinational read.
module sys_feeder_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store one accepted vector per cycle
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sys_input_feeder.sv
// Buffers a batch of 2-lane vectors and streams it
// into the 2x2 systolic array with a one-cycle lane skew.
module sys_input_feeder #(
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data_1,
  input  logic [DATA_W-1:0]         in_data_2,
  input  logic                      in_last,
  input  logic                      go,
  input  logic [tpu_pkg::COL_W-1:0] col_size_in,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         sys_data_in_1x,
  output logic [DATA_W-1:0]         sys_data_in_2x,
  output logic                      sys_start,
  output logic [tpu_pkg::COL_W-1:0] ub_rd_col_size_out,
  output logic                      ub_rd_col_size_valid_out
);

  import tpu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  feeder_state_t r_state;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_last;
  logic [DATA_W-1:0] r_skew;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_start;
  logic              r_col_v;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic [COL_W-1:0]  r_col;

  logic                wr_en_unused;
  logic                w_wr_en;
  logic [2*DATA_W-1:0] w_rd_data;
  logic [CW-1:0]       w_count_inc;
  logic                w_rd_last;

  assign wr_en_unused = 1'b0;
  assign w_wr_en      = (r_state == LOAD) & in_valid & r_in_ready;
  assign w_count_inc  = r_count + ONE;
  assign w_rd_last    = (({1'b0, r_rd_ptr} + ONE) == r_count);

  sys_feeder_buf #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({in_data_2, in_data_1}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Load / stream sequencing; lane 1 and lane-2 staging
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOAD;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last     <= 1'b0;
      r_skew     <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_start    <= 1'b0;
      r_col_v    <= 1'b0;
      r_d1       <= '0;
      r_col      <= '0;
    end else begin
      r_done  <= 1'b0;
      r_col_v <= 1'b0;
      unique case (r_state)
        LOAD: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= w_count_inc;
            if (in_last || (w_count_inc == FULL)) begin
              r_state    <= READY;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        READY: begin
          if (go) begin
            r_col    <= col_size_in;
            r_col_v  <= 1'b1;
            r_start  <= 1'b1;
            r_d1     <= w_rd_data[DATA_W-1:0];
            r_skew   <= w_rd_data[2*DATA_W-1:DATA_W];
            r_last   <= w_rd_last;
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state  <= STREAM;
          end
        end
        STREAM: begin
          if (r_last) begin
            r_start <= 1'b0;
            r_d1    <= '0;
            r_skew  <= '0;
            r_last  <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_d1     <= w_rd_data[DATA_W-1:0];
            r_skew   <= w_rd_data[2*DATA_W-1:DATA_W];
            r_last   <= w_rd_last;
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        DRAIN: begin
          r_state    <= LOAD;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_count    <= '0;
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  // Lane 2 trails lane 1 by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d2 <= '0;
    end else begin
      r_d2 <= r_skew;
    end
  end

  assign in_ready                 = r_in_ready;
  assign busy                     = r_busy;
  assign done                     = r_done;
  assign sys_start                = r_start;
  assign sys_data_in_1x           = r_d1;
  assign sys_data_in_2x           = r_d2;
  assign ub_rd_col_size_out       = r_col;
  assign ub_rd_col_size_valid_out = r_col_v;

endmodule

// File: tb/tb_sys_input_feeder.sv
// Self-checking bench for sys_input_feeder.
// Expected streams come from a per-cycle offset model of the batch.
module tb_sys_input_feeder;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data_1;
  logic [W-1:0] in_data_2;
  logic         in_last;
  logic         go;
  logic [15:0]  col_size_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sys_data_in_1x;
  logic [W-1:0] sys_data_in_2x;
  logic         sys_start;
  logic [15:0]  ub_rd_col_size_out;
  logic         ub_rd_col_size_valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  typedef struct {
    bit           v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           exp_rdy;
    bit           exp_busy;
  } row_t;

  sys_input_feeder #(.DATA_W(W), .DEPTH(D)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .in_data_1                (in_data_1),
    .in_data_2                (in_data_2),
    .in_last                  (in_last),
    .go                       (go),
    .col_size_in              (col_size_in),
    .busy                     (busy),
    .done                     (done),
    .sys_data_in_1x           (sys_data_in_1x),
    .sys_data_in_2x           (sys_data_in_2x),
    .sys_start                (sys_start),
    .ub_rd_col_size_out       (ub_rd_col_size_out),
    .ub_rd_col_size_valid_out (ub_rd_col_size_valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " start"}, 32'(sys_start), 0);
    chk({tag, " lane1"}, 32'(sys_data_in_1x), 0);
    chk({tag, " lane2"}, 32'(sys_data_in_2x), 0);
    chk({tag, " colv"}, 32'(ub_rd_col_size_valid_out), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  // Write a batch; optional idle gaps and go held high throughout
  task automatic load_batch(input vec_t vq[$], input bit use_last,
                            input bit go_glitch, input bit gaps);
    foreach (vq[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        go = go_glitch;
        tick();
      end
      chk("load rdy", 32'(in_ready), 1);
      chk("load busy", 32'(busy), 0);
      chk_idle("load");
      in_valid  = 1'b1;
      in_data_1 = vq[i].a;
      in_data_2 = vq[i].b;
      in_last   = use_last && (i == vq.size() - 1);
      go        = go_glitch;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    go       = 1'b0;
    chk("ready rdy", 32'(in_ready), 0);
    chk("ready busy", 32'(busy), 1);
    chk_idle("ready");
    tick();
    chk("ready hold", 32'(busy), 1);
  endtask

  // Issue go, then compare every cycle against the offset model
  task automatic stream_batch(input vec_t vq[$], input logic [15:0] col,
                              input bit glitch);
    int n;
    n = vq.size();
    go = 1'b1;
    col_size_in = col;
    tick();
    go = 1'b0;
    for (int d = 1; d <= n + 3; d++) begin
      logic         e_s;
      logic [W-1:0] e_1;
      logic [W-1:0] e_2;
      e_s = (d <= n);
      e_1 = e_s ? vq[d-1].a : '0;
      e_2 = (d >= 2 && d <= n + 1) ? vq[d-2].b : '0;
      chk($sformatf("start d%0d", d), 32'(sys_start), 32'(e_s));
      chk($sformatf("lane1 d%0d", d), 32'(sys_data_in_1x), 32'(e_1));
      chk($sformatf("lane2 d%0d", d), 32'(sys_data_in_2x), 32'(e_2));
      chk($sformatf("done d%0d", d), 32'(done), 32'(d == n + 2));
      chk($sformatf("colv d%0d", d), 32'(ub_rd_col_size_valid_out),
          32'(d == 1));
      chk($sformatf("col d%0d", d), 32'(ub_rd_col_size_out), 32'(col));
      chk($sformatf("busy d%0d", d), 32'(busy), 32'(d <= n + 1));
      chk($sformatf("rdy d%0d", d), 32'(in_ready), 32'(d >= n + 2));
      if (glitch && d <= n + 1) begin
        go = 1'b1;
        col_size_in = ~col;
      end else begin
        go = 1'b0;
      end
      tick();
    end
    go = 1'b0;
  endtask

  function automatic vec_t mk(input int a, input int b);
    vec_t v;
    v.a = W'(a);
    v.b = W'(b);
    return v;
  endfunction

  initial begin
    vec_t q[$];
    row_t tbl[18];
    rst = 1'b1;
    in_valid = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    in_last = 1'b0;
    go = 1'b0;
    col_size_in = '0;
    tick();
    tick();
    chk("rst rdy", 32'(in_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst col", 32'(ub_rd_col_size_out), 0);
    chk_idle("rst");
    rst = 1'b0;
    tick();

    q = {mk(1, 2), mk(3, 4), mk(5, 6)};
    load_batch(q, 1'b1, 1'b0, 1'b0);
    stream_batch(q, 16'd2, 1'b0);

    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, W'(i * 3 + 1), W'(i * 5 + 2), 1'b1, 1'b0};
    end
    tbl[16] = '{1'b1, 16'hdead, 16'hbeef, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 16'h0, 16'h0, 1'b0, 1'b1};
    q = {};
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("fill rdy %0d", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("fill busy %0d", i), 32'(busy), 32'(tbl[i].exp_busy));
      in_valid  = tbl[i].v;
      in_data_1 = tbl[i].a;
      in_data_2 = tbl[i].b;
      in_last   = 1'b0;
      if (i < 16) q.push_back(mk(int'(tbl[i].a), int'(tbl[i].b)));
      tick();
    end
    in_valid = 1'b0;
    stream_batch(q, 16'd16, 1'b0);

    q = {mk(7, 9)};
    load_batch(q, 1'b1, 1'b0, 1'b0);
    stream_batch(q, 16'd1, 1'b0);

    q = {mk(11, 12), mk(13, 14), mk(15, 16)};
    load_batch(q, 1'b1, 1'b1, 1'b0);
    stream_batch(q, 16'd2, 1'b1);

    q = {mk(21, 22), mk(23, 24), mk(25, 26), mk(27, 28)};
    load_batch(q, 1'b1, 1'b0, 1'b0);
    go = 1'b1;
    col_size_in = 16'd3;
    tick();
    go = 1'b0;
    chk("rstm start d1", 32'(sys_start), 1);
    chk("rstm lane1 d1", 32'(sys_data_in_1x), 21);
    tick();
    rst = 1'b1;
    #1;
    chk("rstm rdy", 32'(in_ready), 1);
    chk("rstm busy", 32'(busy), 0);
    chk("rstm col", 32'(ub_rd_col_size_out), 0);
    chk_idle("rstm");
    tick();
    chk("rstm done1", 32'(done), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstm post", 32'(done), 0);
      chk("rstm post rdy", 32'(in_ready), 1);
    end
    q = {mk(31, 32), mk(33, 34)};
    load_batch(q, 1'b1, 1'b0, 1'b0);
    stream_batch(q, 16'd2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int  n;
      bit  ul;
      n = $urandom_range(1, D);
      ul = (n < D) ? 1'b1 : 1'($urandom_range(0, 1));
      q = {};
      for (int i = 0; i < n; i++) begin
        q.push_back(mk(int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 65535))));
      end
      load_batch(q, ul, 1'($urandom_range(0, 1)), 1'b1);
      stream_batch(q, 16'($urandom_range(1, 65535)),
                   1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
